// File: rtl/rom_bus_arbiter.sv
// Shares one external PSRAM port between the SNES bus, the S-DD1 fetch unit and the MCU.
// SNES has fixed priority; DD1 and MCU alternate. CE/OE/WE timing and all outputs are registered.
module rom_bus_arbiter #(
  parameter int unsigned ROM_CYCLES = 6
) (
  input  logic        CLK2,
  input  logic        RST_N,
  input  logic        SNES_REQ,
  input  logic [23:0] SNES_ADDR_IN,
  input  logic        SNES_WE,
  input  logic        SNES_WRITABLE,
  input  logic [7:0]  SNES_WDATA,
  input  logic        DD1_REQ,
  input  logic [23:0] DD1_ADDR,
  input  logic        MCU_REQ,
  input  logic [23:0] MCU_ADDR,
  input  logic        MCU_WE,
  input  logic [7:0]  MCU_WDATA,
  input  logic [7:0]  ROM_DATA_IN,
  output logic        SNES_DONE,
  output logic        DD1_DONE,
  output logic        MCU_DONE,
  output logic [7:0]  RDATA,
  output logic [23:0] ROM_ADDR,
  output logic [7:0]  ROM_DATA_OUT,
  output logic        ROM_DATA_OE,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam int unsigned R_SNES = 0;
  localparam int unsigned R_DD1  = 1;
  localparam int unsigned R_MCU  = 2;
  localparam logic [3:0]  CNT_LOAD = 4'(ROM_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  win_q, win_d;
  logic [2:0]  done_q, done_d;
  logic        rr_mcu_q, rr_mcu_d;
  logic        wr_q, wr_d;

  logic [23:0] snes_addr_q, snes_addr_d;
  logic        snes_we_q, snes_we_d;
  logic        snes_wrok_q, snes_wrok_d;
  logic [7:0]  snes_wdata_q, snes_wdata_d;
  logic [23:0] dd1_addr_q, dd1_addr_d;
  logic [23:0] mcu_addr_q, mcu_addr_d;
  logic        mcu_we_q, mcu_we_d;
  logic [7:0]  mcu_wdata_q, mcu_wdata_d;

  logic [23:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_dout_q, rom_dout_d;
  logic        rom_doe_q, rom_doe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [2:0]  gnt;
  logic [23:0] g_addr;
  logic        g_we;
  logic [7:0]  g_wdata;
  logic        g_blk;

  // Winner selection and the winner's latched transaction fields
  always_comb begin
    gnt     = '0;
    g_addr  = '0;
    g_we    = 1'b0;
    g_wdata = '0;
    g_blk   = 1'b0;
    if (pend_q[R_SNES]) begin
      gnt[R_SNES] = 1'b1;
    end else if (pend_q[R_DD1] && (!pend_q[R_MCU] || !rr_mcu_q)) begin
      gnt[R_DD1] = 1'b1;
    end else if (pend_q[R_MCU]) begin
      gnt[R_MCU] = 1'b1;
    end
    if (gnt[R_SNES]) begin
      g_addr  = snes_addr_q;
      g_we    = snes_we_q;
      g_wdata = snes_wdata_q;
      g_blk   = snes_we_q && !snes_wrok_q;
    end else if (gnt[R_DD1]) begin
      g_addr  = dd1_addr_q;
    end else if (gnt[R_MCU]) begin
      g_addr  = mcu_addr_q;
      g_we    = mcu_we_q;
      g_wdata = mcu_wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    win_d        = win_q;
    done_d       = '0;
    rr_mcu_d     = rr_mcu_q;
    wr_d         = wr_q;
    snes_addr_d  = snes_addr_q;
    snes_we_d    = snes_we_q;
    snes_wrok_d  = snes_wrok_q;
    snes_wdata_d = snes_wdata_q;
    dd1_addr_d   = dd1_addr_q;
    mcu_addr_d   = mcu_addr_q;
    mcu_we_d     = mcu_we_q;
    mcu_wdata_d  = mcu_wdata_q;
    rom_addr_d   = rom_addr_q;
    rom_dout_d   = rom_dout_q;
    rom_doe_d    = rom_doe_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    rdata_d      = rdata_q;

    // A winner's flag is still set on its grant edge, so its pulse there is dropped
    if (SNES_REQ && !pend_q[R_SNES]) begin
      pend_d[R_SNES] = 1'b1;
      snes_addr_d    = SNES_ADDR_IN;
      snes_we_d      = SNES_WE;
      snes_wrok_d    = SNES_WRITABLE;
      snes_wdata_d   = SNES_WDATA;
    end
    if (DD1_REQ && !pend_q[R_DD1]) begin
      pend_d[R_DD1] = 1'b1;
      dd1_addr_d    = DD1_ADDR;
    end
    if (MCU_REQ && !pend_q[R_MCU]) begin
      pend_d[R_MCU] = 1'b1;
      mcu_addr_d    = MCU_ADDR;
      mcu_we_d      = MCU_WE;
      mcu_wdata_d   = MCU_WDATA;
    end

    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d    = S_ACCESS;
          cnt_d      = CNT_LOAD;
          pend_d     = pend_d & ~gnt;
          win_d      = gnt;
          wr_d       = g_we;
          rom_addr_d = g_addr;
          if (gnt[R_DD1]) rr_mcu_d = 1'b1;
          if (gnt[R_MCU]) rr_mcu_d = 1'b0;
          if (!g_blk) begin
            ce_n_d = 1'b0;
            if (g_we) begin
              we_n_d     = 1'b0;
              rom_doe_d  = 1'b1;
              rom_dout_d = g_wdata;
            end else begin
              oe_n_d = 1'b0;
            end
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = ROM_DATA_IN;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          rom_doe_d = 1'b0;
          state_d   = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // WE_N rises one cycle before CE_N so write data is held past the strobe
          if (cnt_q == 4'd1) we_n_d = 1'b1;
        end
      end
      S_RECOVER: begin
        done_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK2) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      win_q        <= '0;
      done_q       <= '0;
      rr_mcu_q     <= 1'b0;
      wr_q         <= 1'b0;
      snes_addr_q  <= '0;
      snes_we_q    <= 1'b0;
      snes_wrok_q  <= 1'b0;
      snes_wdata_q <= '0;
      dd1_addr_q   <= '0;
      mcu_addr_q   <= '0;
      mcu_we_q     <= 1'b0;
      mcu_wdata_q  <= '0;
      rom_addr_q   <= '0;
      rom_dout_q   <= '0;
      rom_doe_q    <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      win_q        <= win_d;
      done_q       <= done_d;
      rr_mcu_q     <= rr_mcu_d;
      wr_q         <= wr_d;
      snes_addr_q  <= snes_addr_d;
      snes_we_q    <= snes_we_d;
      snes_wrok_q  <= snes_wrok_d;
      snes_wdata_q <= snes_wdata_d;
      dd1_addr_q   <= dd1_addr_d;
      mcu_addr_q   <= mcu_addr_d;
      mcu_we_q     <= mcu_we_d;
      mcu_wdata_q  <= mcu_wdata_d;
      rom_addr_q   <= rom_addr_d;
      rom_dout_q   <= rom_dout_d;
      rom_doe_q    <= rom_doe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      rdata_q      <= rdata_d;
    end
  end

  assign SNES_DONE    = done_q[R_SNES];
  assign DD1_DONE     = done_q[R_DD1];
  assign MCU_DONE     = done_q[R_MCU];
  assign RDATA        = rdata_q;
  assign ROM_ADDR     = rom_addr_q;
  assign ROM_DATA_OUT = rom_dout_q;
  assign ROM_DATA_OE  = rom_doe_q;
  assign ROM_CE_N     = ce_n_q;
  assign ROM_OE_N     = oe_n_q;
  assign ROM_WE_N     = we_n_q;
  assign BUSY         = (state_q != S_IDLE);

endmodule
